// File: rtl/rob_mp.sv
// rtl/rob_mp.sv - multi-port reorder buffer: in-order allocate, multi-port CDB
// completion, two operand snoop ports, up to COMMIT_WIDTH retires per cycle.
module rob_mp #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ADDR_WIDTH     = 3,
  parameter int CDB_PORTS      = 2,
  parameter int COMMIT_WIDTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall_i,
  input  logic                                 flush_i,
  input  logic                                 issue_en_i,
  input  logic                                 issue_valid_i,
  input  logic [XLEN-1:0]                      issue_value_i,
  input  logic [REG_ADDR_WIDTH-1:0]            issue_dest_i,
  output logic [ADDR_WIDTH-1:0]                issue_tag_o,
  input  logic [CDB_PORTS-1:0]                 cdb_valid_i,
  input  logic [CDB_PORTS*ADDR_WIDTH-1:0]      cdb_tag_i,
  input  logic [CDB_PORTS*XLEN-1:0]            cdb_value_i,
  input  logic [ADDR_WIDTH-1:0]                rs1_tag_i,
  input  logic [ADDR_WIDTH-1:0]                rs2_tag_i,
  output logic                                 rs1_valid_o,
  output logic                                 rs2_valid_o,
  output logic [XLEN-1:0]                      rs1_value_o,
  output logic [XLEN-1:0]                      rs2_value_o,
  output logic [COMMIT_WIDTH-1:0]              commit_en_o,
  output logic [COMMIT_WIDTH*REG_ADDR_WIDTH-1:0] commit_dest_o,
  output logic [COMMIT_WIDTH*XLEN-1:0]         commit_value_o,
  output logic [ADDR_WIDTH-1:0]                head_tag_o,
  output logic [ADDR_WIDTH:0]                  count_o,
  output logic                                 full_o,
  output logic                                 empty_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [DEPTH-1:0]          busy_q, done_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q [DEPTH];
  logic [XLEN-1:0]           value_q [DEPTH];
  logic [PW-1:0]             head_q, tail_q, count_q;

  logic [ADDR_WIDTH-1:0]     cidx [COMMIT_WIDTH];
  logic [PW-1:0]             n_ret;
  logic                      commit_run;
  logic                      issue_ok;
  logic [ADDR_WIDTH-1:0]     tail_idx;

  assign tail_idx    = tail_q[ADDR_WIDTH-1:0];
  assign issue_tag_o = tail_idx;
  assign head_tag_o  = head_q[ADDR_WIDTH-1:0];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);
  // Wrap bits differ with equal indices only when every entry is occupied.
  assign full_o      = (head_q[ADDR_WIDTH] != tail_q[ADDR_WIDTH]) &&
                       (head_q[ADDR_WIDTH-1:0] == tail_idx);
  assign issue_ok    = issue_en_i && !full_o && !stall_i && !flush_i;

  always_comb begin
    commit_run     = !stall_i && !flush_i;
    n_ret          = '0;
    commit_en_o    = '0;
    commit_dest_o  = '0;
    commit_value_o = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      cidx[j]    = head_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(j);
      commit_run = commit_run && busy_q[cidx[j]] && done_q[cidx[j]];
      commit_en_o[j] = commit_run;
      if (commit_run) n_ret = n_ret + PW'(1);
      commit_dest_o[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = dest_q[cidx[j]];
      commit_value_o[j*XLEN +: XLEN]                    = value_q[cidx[j]];
    end
  end

  logic [ADDR_WIDTH-1:0] snp_tag   [2];
  logic                  snp_valid [2];
  logic [XLEN-1:0]       snp_value [2];

  assign snp_tag[0]  = rs1_tag_i;
  assign snp_tag[1]  = rs2_tag_i;
  assign rs1_valid_o = snp_valid[0];
  assign rs2_valid_o = snp_valid[1];
  assign rs1_value_o = snp_value[0];
  assign rs2_value_o = snp_value[1];

  // Ascending port loop lets the highest-index CDB hit override.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      snp_valid[s] = 1'b0;
      snp_value[s] = '0;
      if (busy_q[snp_tag[s]]) begin
        snp_valid[s] = done_q[snp_tag[s]];
        snp_value[s] = value_q[snp_tag[s]];
        for (int k = 0; k < CDB_PORTS; k++) begin
          if (cdb_valid_i[k] && cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH] == snp_tag[s]) begin
            snp_valid[s] = 1'b1;
            snp_value[s] = cdb_value_i[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (!stall_i) begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (commit_en_o[j]) begin
          busy_q[cidx[j]] <= 1'b0;
          done_q[cidx[j]] <= 1'b0;
        end
      end
      for (int k = 0; k < CDB_PORTS; k++) begin
        if (cdb_valid_i[k] && busy_q[cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH]] &&
            !done_q[cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH]])
          done_q[cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
      end
      if (issue_ok) begin
        busy_q[tail_idx] <= 1'b1;
        done_q[tail_idx] <= issue_valid_i;
        tail_q           <= tail_q + PW'(1);
      end
      head_q  <= head_q + n_ret;
      count_q <= count_q + {{ADDR_WIDTH{1'b0}}, issue_ok} - n_ret;
    end
  end

  // Payload storage needs no reset: busy/done qualify every read.
  always_ff @(posedge clk) begin
    if (!flush_i && !stall_i) begin
      for (int k = 0; k < CDB_PORTS; k++) begin
        if (cdb_valid_i[k] && busy_q[cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH]] &&
            !done_q[cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH]])
          value_q[cdb_tag_i[k*ADDR_WIDTH +: ADDR_WIDTH]] <= cdb_value_i[k*XLEN +: XLEN];
      end
      if (issue_ok) begin
        dest_q[tail_idx]  <= issue_dest_i;
        value_q[tail_idx] <= issue_value_i;
      end
    end
  end
endmodule

// File: tb/tb_rob_mp.sv
// tb/tb_rob_mp.sv - table-driven bench for rob_mp with an in-order commit scoreboard.
module tb_rob_mp;
  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, issue_en_i, issue_valid_i;
  logic [31:0] issue_value_i;
  logic [4:0]  issue_dest_i;
  logic [2:0]  issue_tag_o, head_tag_o, rs1_tag_i, rs2_tag_i;
  logic [1:0]  cdb_valid_i;
  logic [5:0]  cdb_tag_i;
  logic [63:0] cdb_value_i;
  logic        rs1_valid_o, rs2_valid_o, full_o, empty_o;
  logic [31:0] rs1_value_o, rs2_value_o;
  logic [1:0]  commit_en_o;
  logic [9:0]  commit_dest_o;
  logic [63:0] commit_value_o;
  logic [3:0]  count_o;

  rob_mp dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .issue_en_i(issue_en_i), .issue_valid_i(issue_valid_i),
    .issue_value_i(issue_value_i), .issue_dest_i(issue_dest_i),
    .issue_tag_o(issue_tag_o), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
    .cdb_value_i(cdb_value_i), .rs1_tag_i(rs1_tag_i), .rs2_tag_i(rs2_tag_i),
    .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o),
    .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
    .commit_en_o(commit_en_o), .commit_dest_o(commit_dest_o),
    .commit_value_o(commit_value_o), .head_tag_o(head_tag_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stall, flush, ie, iv;
    logic [4:0]  d;
    logic [31:0] v, sbv;
    logic [1:0]  cv;
    logic [5:0]  ct;
    logic [63:0] cval;
    int          cnt;
    logic [1:0]  cen;
  } row_t;

  int          checks = 0;
  int          errors = 0;
  logic [36:0] sb_q [$];
  logic [36:0] sb_e;
  row_t        tbl [$];
  row_t        r;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  function automatic row_t idle(int cnt, logic [1:0] cen);
    row_t x;
    x.stall = 0; x.flush = 0; x.ie = 0; x.iv = 0; x.d = '0; x.v = '0; x.sbv = '0;
    x.cv = '0; x.ct = '0; x.cval = '0; x.cnt = cnt; x.cen = cen;
    return x;
  endfunction

  function automatic row_t iss(bit iv, logic [4:0] d, logic [31:0] v, logic [31:0] sbv,
                               int cnt, logic [1:0] cen);
    row_t x = idle(cnt, cen);
    x.ie = 1; x.iv = iv; x.d = d; x.v = v; x.sbv = sbv;
    return x;
  endfunction

  function automatic row_t cdb(logic [1:0] cv, logic [2:0] t0, logic [31:0] v0,
                               logic [2:0] t1, logic [31:0] v1, int cnt, logic [1:0] cen);
    row_t x = idle(cnt, cen);
    x.cv = cv; x.ct = {t1, t0}; x.cval = {v1, v0};
    return x;
  endfunction

  // Drive one cycle of stimulus, queue the expected retirement, check pre-edge outputs.
  task automatic apply(input row_t x);
    @(posedge clk); #1;
    stall_i = x.stall; flush_i = x.flush; issue_en_i = x.ie; issue_valid_i = x.iv;
    issue_dest_i = x.d; issue_value_i = x.v;
    cdb_valid_i = x.cv; cdb_tag_i = x.ct; cdb_value_i = x.cval;
    if (x.ie && !x.stall && !x.flush && x.cnt < 8) sb_q.push_back({x.d, x.sbv});
    if (x.flush) sb_q.delete();
    @(negedge clk);
    chk("count", 64'(count_o), 64'(x.cnt));
    chk("commit_en", 64'(commit_en_o), 64'(x.cen));
    chk("full", 64'(full_o), 64'(x.cnt == 8));
    chk("empty", 64'(empty_o), 64'(x.cnt == 0));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 2; j++) begin
        if (commit_en_o[j]) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL commit_unexpected slot=%0d actual=1 expected=0", j);
          end else begin
            sb_e = sb_q.pop_front();
            chk("commit_dest", 64'(commit_dest_o[j*5 +: 5]), 64'(sb_e[36:32]));
            chk("commit_value", 64'(commit_value_o[j*32 +: 32]), 64'(sb_e[31:0]));
          end
        end
      end
    end
  end

  task automatic chk_ids(logic [2:0] it, logic [2:0] ht);
    chk("issue_tag", 64'(issue_tag_o), 64'(it));
    chk("head_tag", 64'(head_tag_o), 64'(ht));
  endtask

  initial begin
    rst = 1; stall_i = 0; flush_i = 0; issue_en_i = 0; issue_valid_i = 0;
    issue_value_i = '0; issue_dest_i = '0; cdb_valid_i = '0; cdb_tag_i = '0;
    cdb_value_i = '0; rs1_tag_i = '0; rs2_tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count_o), 0);
    chk("rst_empty", 64'(empty_o), 1);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_commit_en", 64'(commit_en_o), 0);
    chk_ids(3'd0, 3'd0);
    rst = 0;

    // Fill: tag 0 held incomplete so the buffer fills, then drains two per cycle.
    tbl.push_back(iss(0, 5'd1, 32'h0, 32'h10, 0, 2'b00));
    for (int i = 1; i < 8; i++)
      tbl.push_back(iss(1, 5'(i + 1), 32'h10 + 32'(i), 32'h10 + 32'(i), i, 2'b00));
    tbl.push_back(iss(1, 5'd9, 32'h99, 32'h99, 8, 2'b00));
    tbl.push_back(cdb(2'b01, 3'd0, 32'h10, 3'd0, 32'h0, 8, 2'b00));
    tbl.push_back(idle(8, 2'b11));
    tbl.push_back(idle(6, 2'b11));
    tbl.push_back(idle(4, 2'b11));
    tbl.push_back(idle(2, 2'b11));
    tbl.push_back(idle(0, 2'b00));
    // Out-of-order CDB completion, head blocking, then a double retire.
    tbl.push_back(iss(0, 5'd10, 32'h0, 32'hAA, 0, 2'b00));
    tbl.push_back(iss(0, 5'd11, 32'h0, 32'hCC, 1, 2'b00));
    tbl.push_back(iss(0, 5'd12, 32'h0, 32'hBB, 2, 2'b00));
    tbl.push_back(cdb(2'b11, 3'd2, 32'hBB, 3'd0, 32'hAA, 3, 2'b00));
    tbl.push_back(idle(3, 2'b01));
    tbl.push_back(cdb(2'b01, 3'd1, 32'hCC, 3'd0, 32'h0, 2, 2'b00));
    tbl.push_back(idle(2, 2'b11));
    tbl.push_back(idle(0, 2'b00));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    chk_ids(3'd3, 3'd3);

    // Snoop forwarding from CDB port 1 and snoop of a free tag.
    apply(iss(0, 5'd13, 32'h0, 32'h55, 0, 2'b00));
    rs1_tag_i = 3'd3; rs2_tag_i = 3'd4;
    apply(idle(1, 2'b00));
    chk("snoop_pending_valid", 64'(rs1_valid_o), 0);
    apply(cdb(2'b10, 3'd0, 32'h0, 3'd3, 32'h55, 1, 2'b00));
    chk("snoop_hit_valid", 64'(rs1_valid_o), 1);
    chk("snoop_hit_value", 64'(rs1_value_o), 64'h55);
    chk("snoop_free_valid", 64'(rs2_valid_o), 0);
    chk("snoop_free_value", 64'(rs2_value_o), 0);
    apply(idle(1, 2'b01));
    apply(idle(0, 2'b00));

    // Stall: issue and CDB both blocked, then commit gating, then a wrap-spanning retire.
    for (int i = 0; i < 5; i++)
      apply(iss(0, 5'(20 + i), 32'h0, 32'h60 + 32'(i), i, 2'b00));
    for (int i = 0; i < 3; i++) begin
      r = iss(1, 5'd30, 32'h77, 32'h77, 5, 2'b00);
      r.stall = 1; r.cv = 2'b01; r.ct = 6'd4; r.cval = 64'h99;
      apply(r);
      chk_ids(3'd1, 3'd4);
    end
    apply(idle(5, 2'b00));
    apply(cdb(2'b01, 3'd4, 32'h60, 3'd0, 32'h0, 5, 2'b00));
    r = idle(5, 2'b00); r.stall = 1;
    apply(r);
    apply(cdb(2'b11, 3'd5, 32'h61, 3'd6, 32'h62, 5, 2'b01));
    apply(cdb(2'b11, 3'd7, 32'h63, 3'd0, 32'h64, 4, 2'b11));
    chk_ids(3'd1, 3'd5);
    apply(idle(2, 2'b11));
    chk_ids(3'd1, 3'd7);
    apply(idle(0, 2'b00));

    // Flush with a simultaneous issue.
    for (int i = 0; i < 6; i++)
      apply(iss(0, 5'(1 + i), 32'h0, 32'h0, i, 2'b00));
    r = iss(1, 5'd9, 32'h90, 32'h90, 6, 2'b00); r.flush = 1;
    apply(r);
    apply(idle(0, 2'b00));
    chk_ids(3'd0, 3'd0);
    apply(iss(1, 5'd7, 32'h70, 32'h70, 0, 2'b00));
    apply(idle(1, 2'b01));
    apply(idle(0, 2'b00));

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++)
      apply(iss(0, 5'(2 + i), 32'h0, 32'h0, i, 2'b00));
    apply(idle(4, 2'b00));
    @(posedge clk); #2;
    chk("pre_arst_count", 64'(count_o), 4);
    #1 rst = 1;
    #1;
    chk("arst_count", 64'(count_o), 0);
    chk("arst_empty", 64'(empty_o), 1);
    chk("arst_full", 64'(full_o), 0);
    chk("arst_commit_en", 64'(commit_en_o), 0);
    chk_ids(3'd0, 3'd0);
    sb_q.delete();
    @(posedge clk); #1 rst = 0;
    apply(idle(0, 2'b00));
    chk("scoreboard_drained", 64'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
